uart_tx_arbiter: RTL

- Shares the single UART transmitter among N_REQ byte producers (command echo, status reporter, debug dump, etc.).
- Round-robin fairness; exactly one byte in flight at a time.
- Drives the transmitter's input_data/tx_start and consumes its tx_done pulse.
- Sits between the producers and the transmitter inside the UART top level.

---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_rr_picker.sv | 32 +++
 rtl/uart_tx_arbiter.sv | 123 ++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit-side blocks.
// FSM encoding, default byte width and a width helper.
package uart_pkg;

  localparam int DEF_D_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2
  } state_e;

  function automatic int clog2(input int n);
    int w;
    w = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < n) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/uart_rr_picker.sv
// Rotating-priority encoder: first valid requester at or after rr_ptr_i,
// wrapping modulo N_REQ.
module uart_rr_picker
  import uart_pkg::*;
#(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0]        req_valid_i,
  input  logic [clog2(N_REQ)-1:0] rr_ptr_i,
  output logic [clog2(N_REQ)-1:0] pick_o,
  output logic                    any_valid_o
);

  localparam int GW = clog2(N_REQ);

  int idx;

  // Walk offsets from farthest to nearest so the nearest valid wins.
  always_comb begin
    pick_o      = '0;
    any_valid_o = 1'b0;
    idx         = 0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = (int'(rr_ptr_i) + k) % N_REQ;
      if (req_valid_i[idx]) begin
        pick_o      = GW'(idx);
        any_valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin share of one UART transmitter among N_REQ byte producers.
// Define UART_TX_ARB_TIMEOUT_EN to add a tx_done watchdog (timeout_err).
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int N_REQ       = 4,
  parameter int D_W         = DEF_D_W,
  parameter int TIMEOUT_CYC = 2000000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*D_W-1:0]    req_data,
  output logic [N_REQ-1:0]        req_ready,
  output logic [D_W-1:0]          input_data,
  output logic                    tx_start,
  input  logic                    tx_done,
  output logic [clog2(N_REQ)-1:0] grant_id,
  output logic                    busy,
  output logic                    timeout_err
);

  localparam int GW = clog2(N_REQ);
  localparam logic [GW-1:0] LAST = GW'(N_REQ - 1);

  state_e         state_q, state_d;
  logic [GW-1:0]  rr_ptr_q, rr_ptr_d;
  logic [GW-1:0]  gid_q, gid_d;
  logic [D_W-1:0] data_q, data_d;
  logic [GW-1:0]  pick;
  logic [GW-1:0]  next_ptr;
  logic           any_valid;
  logic           expire;

  uart_rr_picker #(
    .N_REQ(N_REQ)
  ) u_picker (
    .req_valid_i(req_valid),
    .rr_ptr_i   (rr_ptr_q),
    .pick_o     (pick),
    .any_valid_o(any_valid)
  );

  assign next_ptr = (gid_q == LAST) ? '0 : gid_q + GW'(1);

`ifdef UART_TX_ARB_TIMEOUT_EN
  logic [31:0] wd_q, wd_d;
  logic        to_q;

  // Counter is zero in the first WAIT cycle and counts WAIT cycles.
  assign expire = (state_q == ST_WAIT) && !tx_done &&
                  (wd_q == 32'(TIMEOUT_CYC - 1));

  always_comb begin
    wd_d = '0;
    if (state_q == ST_WAIT) wd_d = wd_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wd_q <= '0;
      to_q <= 1'b0;
    end else begin
      wd_q <= wd_d;
      to_q <= expire;
    end
  end

  assign timeout_err = to_q;
`else
  assign expire      = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    gid_d     = gid_q;
    data_d    = data_q;
    req_ready = '0;
    tx_start  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (any_valid) begin
          req_ready[pick] = ~rst;
          data_d          = req_data[pick*D_W +: D_W];
          gid_d           = pick;
          state_d         = ST_START;
        end
      end
      ST_START: begin
        tx_start = 1'b1;
        state_d  = ST_WAIT;
      end
      ST_WAIT: begin
        if (tx_done || expire) begin
          rr_ptr_d = next_ptr;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      rr_ptr_q <= '0;
      gid_q    <= '0;
      data_q   <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      gid_q    <= gid_d;
      data_q   <= data_d;
    end
  end

  assign input_data = data_q;
  assign grant_id   = gid_q;
  assign busy       = (state_q != ST_IDLE);

endmodule
